// File: rtl/edge_stamp_pkg.sv
// Shared types and constants for the edge_stamp block.
// Stamps are {window cycle count, TDC fraction}; the value 0 is reserved
// to flag a window without an edge of that polarity.
package edge_stamp_pkg;

    localparam int unsigned INT_W   = 6;
    localparam int unsigned FRAC_W  = 6;
    localparam int unsigned STAMP_W = INT_W + FRAC_W;

    localparam int unsigned NULL_STAMP = 0;
    localparam int unsigned MIN_STAMP  = 1;
    localparam int unsigned MIN_WIN    = 2;

    typedef logic [STAMP_W-1:0] stamp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Build a stamp, lifting a genuine edge at cnt=0/frac=0 off the null code.
    function automatic stamp_t make_stamp(input logic [INT_W-1:0]  cnt,
                                          input logic [FRAC_W-1:0] frac);
        stamp_t s;
        s = {cnt, frac};
        if (s == STAMP_W'(NULL_STAMP)) begin
            s = STAMP_W'(MIN_STAMP);
        end
        return s;
    endfunction

endpackage

// File: rtl/edge_stamp_det.sv
// Edge detector for edge_stamp: holds the previous din level and produces
// rise/fall strobes plus the stamp that belongs to the strobed edge.
// Build option EDGE_STAMP_DEGLITCH_EN: a new level must persist for two
// cycles before it is accepted; the stamp comes from the first cycle of the
// new level, so strobes arrive one cycle after the level change.
// Ports:
//   clk, rst      clock, async active-high reset
//   arm           window arming cycle: resync history to din
//   run           window running: track din and allow strobes
//   din           data level
//   cnt, frac_in  window cycle count and TDC phase of the current cycle
//   rise_c/fall_c edge strobes (combinational)
//   stamp_c       stamp of the strobed edge (combinational)
module edge_stamp_det
    import edge_stamp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              run,
    input  logic              din,
    input  logic [INT_W-1:0]  cnt,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              rise_c,
    output logic              fall_c,
    output stamp_t            stamp_c
);

    logic din_q;

`ifdef EDGE_STAMP_DEGLITCH_EN
    logic   lvl_q;      // accepted (filtered) level
    stamp_t pend_q;     // stamp of the first cycle of the latest raw change
    logic   confirm_c;

    // New level seen for the second consecutive cycle and differs from accepted level.
    assign confirm_c = run && (din == din_q) && (din != lvl_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q  <= 1'b0;
            lvl_q  <= 1'b0;
            pend_q <= STAMP_W'(NULL_STAMP);
        end else if (arm) begin
            din_q <= din;
            lvl_q <= din;
        end else if (run) begin
            din_q <= din;
            if (din != din_q) begin
                pend_q <= make_stamp(cnt, frac_in);
            end
            if (confirm_c) begin
                lvl_q <= din;
            end
        end
    end

    assign rise_c  = confirm_c & din;
    assign fall_c  = confirm_c & ~din;
    assign stamp_c = pend_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else if (arm || run) begin
            din_q <= din;
        end
    end

    assign rise_c  = run & din & ~din_q;
    assign fall_c  = run & ~din & din_q;
    assign stamp_c = make_stamp(cnt, frac_in);
`endif

endmodule

// File: rtl/edge_stamp.sv
// Windowed edge timestamper feeding the DPLL period estimator.
// Each window of win_len cycles (min 2) captures the first rise and first
// fall as {cnt, frac_in}; at window end both are published together with a
// one-cycle stamp_valid pulse. Missing edges publish as 0.
// Build option EDGE_STAMP_DEGLITCH_EN: two-cycle glitch filter on din; the
// publish is delayed one cycle so an edge pending at window end is credited
// to the window it started in.
// Ports:
//   clk, rst      clock, async active-high reset
//   enable        run windows while high
//   din           data level (synchronous to clk)
//   frac_in       sub-cycle phase of a din transition this cycle
//   win_len       window length, sampled at window start
//   edges1/edges2 rise/fall stamps of the last completed window
//   stamp_valid   one-cycle pulse when edges1/edges2/multi_edge update
//   multi_edge    last window had a repeated rise or fall
module edge_stamp
    import edge_stamp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               din,
    input  logic [FRAC_W-1:0]  frac_in,
    input  logic [INT_W-1:0]   win_len,
    output logic [STAMP_W-1:0] edges1,
    output logic [STAMP_W-1:0] edges2,
    output logic               stamp_valid,
    output logic               multi_edge
);

    state_t           state_q, state_d;
    logic [INT_W-1:0] cnt_q, cnt_d;
    logic [INT_W-1:0] wl_q, wl_d;
    logic [INT_W-1:0] wl_load_c;
    stamp_t           rise_q, rise_d, fall_q, fall_d;
    logic             multi_q, multi_d;
    stamp_t           edges1_d, edges2_d;
    logic             stamp_valid_d, multi_edge_d;

    logic             arm_c, run_c, win_end_c, late_c;
    logic             rise_c, fall_c;
    stamp_t           stamp_c;
    stamp_t           rise_nxt_c, fall_nxt_c;
    logic             multi_nxt_c;

`ifdef EDGE_STAMP_DEGLITCH_EN
    logic             dly_q, dly_d;
    stamp_t           hold_rise_q, hold_rise_d, hold_fall_q, hold_fall_d;
    logic             hold_multi_q, hold_multi_d;

    // Strobes in the cycle after a window end belong to the finished window.
    assign late_c = dly_q;
`else
    assign late_c = 1'b0;
`endif

    assign arm_c     = (state_q == ARM);
    assign run_c     = (state_q == RUN);
    assign win_end_c = (cnt_q == (wl_q - INT_W'(1)));
    assign wl_load_c = (win_len < INT_W'(MIN_WIN)) ? INT_W'(MIN_WIN) : win_len;

    edge_stamp_det u_det (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm_c),
        .run     (run_c),
        .din     (din),
        .cnt     (cnt_q),
        .frac_in (frac_in),
        .rise_c  (rise_c),
        .fall_c  (fall_c),
        .stamp_c (stamp_c)
    );

    // Next-state, window capture and publish.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wl_d          = wl_q;
        rise_d        = rise_q;
        fall_d        = fall_q;
        multi_d       = multi_q;
        edges1_d      = edges1;
        edges2_d      = edges2;
        multi_edge_d  = multi_edge;
        stamp_valid_d = 1'b0;
`ifdef EDGE_STAMP_DEGLITCH_EN
        dly_d         = 1'b0;
        hold_rise_d   = hold_rise_q;
        hold_fall_d   = hold_fall_q;
        hold_multi_d  = hold_multi_q;
`endif

        // Capture state including this cycle's edges (bypass for window end).
        rise_nxt_c  = rise_q;
        fall_nxt_c  = fall_q;
        multi_nxt_c = multi_q;
        if (rise_c && !late_c) begin
            if (rise_q == STAMP_W'(NULL_STAMP)) rise_nxt_c  = stamp_c;
            else                                multi_nxt_c = 1'b1;
        end
        if (fall_c && !late_c) begin
            if (fall_q == STAMP_W'(NULL_STAMP)) fall_nxt_c  = stamp_c;
            else                                multi_nxt_c = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                cnt_d   = '0;
                wl_d    = wl_load_c;
                rise_d  = STAMP_W'(NULL_STAMP);
                fall_d  = STAMP_W'(NULL_STAMP);
                multi_d = 1'b0;
                state_d = enable ? RUN : IDLE;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (win_end_c) begin
                    cnt_d   = '0;
                    wl_d    = wl_load_c;
                    rise_d  = STAMP_W'(NULL_STAMP);
                    fall_d  = STAMP_W'(NULL_STAMP);
                    multi_d = 1'b0;
`ifdef EDGE_STAMP_DEGLITCH_EN
                    dly_d        = 1'b1;
                    hold_rise_d  = rise_nxt_c;
                    hold_fall_d  = fall_nxt_c;
                    hold_multi_d = multi_nxt_c;
`else
                    edges1_d      = rise_nxt_c;
                    edges2_d      = fall_nxt_c;
                    multi_edge_d  = multi_nxt_c;
                    stamp_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + INT_W'(1);
                    rise_d  = rise_nxt_c;
                    fall_d  = fall_nxt_c;
                    multi_d = multi_nxt_c;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef EDGE_STAMP_DEGLITCH_EN
        // Delayed publish of the held window plus any edge confirmed late.
        if (dly_q) begin
            edges1_d     = hold_rise_q;
            edges2_d     = hold_fall_q;
            multi_edge_d = hold_multi_q;
            if (rise_c) begin
                if (hold_rise_q == STAMP_W'(NULL_STAMP)) edges1_d     = stamp_c;
                else                                     multi_edge_d = 1'b1;
            end
            if (fall_c) begin
                if (hold_fall_q == STAMP_W'(NULL_STAMP)) edges2_d     = stamp_c;
                else                                     multi_edge_d = 1'b1;
            end
            stamp_valid_d = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wl_q         <= INT_W'(MIN_WIN);
            rise_q       <= STAMP_W'(NULL_STAMP);
            fall_q       <= STAMP_W'(NULL_STAMP);
            multi_q      <= 1'b0;
            edges1       <= STAMP_W'(NULL_STAMP);
            edges2       <= STAMP_W'(NULL_STAMP);
            multi_edge   <= 1'b0;
            stamp_valid  <= 1'b0;
`ifdef EDGE_STAMP_DEGLITCH_EN
            dly_q        <= 1'b0;
            hold_rise_q  <= STAMP_W'(NULL_STAMP);
            hold_fall_q  <= STAMP_W'(NULL_STAMP);
            hold_multi_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wl_q         <= wl_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            multi_q      <= multi_d;
            edges1       <= edges1_d;
            edges2       <= edges2_d;
            multi_edge   <= multi_edge_d;
            stamp_valid  <= stamp_valid_d;
`ifdef EDGE_STAMP_DEGLITCH_EN
            dly_q        <= dly_d;
            hold_rise_q  <= hold_rise_d;
            hold_fall_q  <= hold_fall_d;
            hold_multi_q <= hold_multi_d;
`endif
        end
    end

endmodule
